// File: rtl/pulse_divider.sv
// rtl/pulse_divider.sv - programmable clock divider producing clk_out, a rise tick and a saturating period count.
// Optional PULSE_DIVIDER_AUTOSTOP_EN returns to IDLE when cycles saturates.
module pulse_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] cycles
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] CMAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] half_q, half_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cycles_q, cycles_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             fall;
  logic             sat_now;

  // half_q is never 0 in RUN, so half_q-1 cannot underflow
  assign wrap    = (cnt_q == half_q - WIDTH'(1));
  assign fall    = wrap && clk_out_q;
  assign sat_now = fall && (cycles_q == CMAX - WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      half_q    <= '0;
      cnt_q     <= '0;
      cycles_q  <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      cycles_q  <= cycles_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !stop && (div != '0)) state_d = RUN;
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end
`ifdef PULSE_DIVIDER_AUTOSTOP_EN
        else if (sat_now) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    half_d    = half_q;
    cnt_d     = cnt_q;
    cycles_d  = cycles_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop && (div != '0)) begin
          half_d   = div;
          cnt_d    = '0;
          cycles_d = '0;
        end
      end
      RUN: begin
        if (stop) begin
          cnt_d     = '0;
          clk_out_d = 1'b0;
        end else if (wrap) begin
          cnt_d     = '0;
          clk_out_d = ~clk_out_q;
          tick_d    = ~clk_out_q;
          if (fall && (cycles_q != CMAX)) cycles_d = cycles_q + WIDTH'(1);
`ifdef PULSE_DIVIDER_AUTOSTOP_EN
          if (sat_now) clk_out_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy    = (state_q == RUN);
    clk_out = clk_out_q;
    tick    = tick_q;
    cycles  = cycles_q;
  end

endmodule

// File: tb/tb_pulse_divider.sv
// tb/tb_pulse_divider.sv - directed-vector bench for pulse_divider (WIDTH=8 and WIDTH=2 instances).
module tb_pulse_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0;
  logic [7:0] div = '0;
  logic       clk_out, tick, busy;
  logic [7:0] cycles;

  logic       start2 = 1'b0, stop2 = 1'b0;
  logic [1:0] div2 = '0;
  logic       clk_out2, tick2, busy2;
  logic [1:0] cycles2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pulse_divider #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .div(div),
    .clk_out(clk_out), .tick(tick), .busy(busy), .cycles(cycles)
  );

  pulse_divider #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .stop(stop2), .div(div2),
    .clk_out(clk_out2), .tick(tick2), .busy(busy2), .cycles(cycles2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_busy2", busy2, 0);

    // reset during RUN
    div = 8'd5; start = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    chk("run_busy", busy, 1);
    chk("run_clk", clk_out, 1);
    reset = 1'b1;
    step(1);
    chk("rr_clk", clk_out, 0);
    chk("rr_tick", tick, 0);
    chk("rr_busy", busy, 0);
    chk("rr_cycles", cycles, 0);
    step(1);
    reset = 1'b0;

    // div=3 waveform
    div = 8'd3; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("d3_busy", busy, 1);
    chk("d3_clk0", clk_out, 0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("d3_clk", clk_out, ((k / 3) % 2));
      chk("d3_tick", tick, (k % 6 == 3));
      if (k == 6) chk("d3_cyc1", cycles, 1);
    end
    chk("d3_cyc2", cycles, 2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("d3_stop_busy", busy, 0);

    // div=0 ignored
    div = 8'd0; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("d0_busy", busy, 0);
      chk("d0_clk", clk_out, 0);
      step(1);
    end

    // div=4, stop while clk_out high
    div = 8'd4; start = 1'b1;
    step(1);
    start = 1'b0;
    step(8);
    chk("d4_cyc1", cycles, 1);
    step(4);
    chk("d4_clk_hi", clk_out, 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("d4_stop_clk", clk_out, 0);
    chk("d4_stop_busy", busy, 0);
    chk("d4_stop_tick", tick, 0);
    chk("d4_hold_cyc", cycles, 1);
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_cyc", cycles, 1);

    // div=1, mid-run div change ignored
    div = 8'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) div = 8'd7;
      step(1);
      chk("d1_clk", clk_out, k % 2);
      chk("d1_tick", tick, k % 2);
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;

    // WIDTH=2 saturation
    div2 = 2'd1; start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    chk("w2_busy", busy2, 1);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("w2_cyc", cycles2, (k / 2 > 3) ? 3 : k / 2);
`ifdef PULSE_DIVIDER_AUTOSTOP_EN
      chk("w2_busy", busy2, (k < 6));
      chk("w2_clk", clk_out2, (k < 6) ? (k % 2) : 0);
`else
      chk("w2_busy", busy2, 1);
      chk("w2_clk", clk_out2, k % 2);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
